// File: rtl/up_down_counter_pkg.sv
// Shared width and count type for the loadable up/down counter.
package up_down_counter_pkg;

    localparam int CNT_WIDTH = 16;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/up_down_counter.sv
// Loadable up/down counter with count enable, async active-low reset.
// Load (active-low) takes priority over counting; arithmetic wraps modulo 2^WIDTH.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ld_cnt,
    input  logic             updn_cnt,
    input  logic             count_enb,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // data_in is only selected under load, so an idle data_in never reaches the register.
    always_comb begin
        w_next = r_count;
        if (!ld_cnt) begin
            w_next = data_in;
        end else if (count_enb) begin
            if (updn_cnt) begin
                w_next = r_count + WIDTH'(1);
            end else begin
                w_next = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign data_out = r_count;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter.
module tb_up_down_counter;

    logic        clk;
    logic        rst_;
    logic        ld_cnt;
    logic        updn_cnt;
    logic        count_enb;
    logic [15:0] data_in;
    logic [15:0] data_out;

    int n_total;
    int n_bad;

    up_down_counter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .ld_cnt    (ld_cnt),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; ld_cnt = 1'b0; updn_cnt = 1'b0; count_enb = 1'b0; data_in = 16'h0000;
        step();
        n_total++;
        if (data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_during got=%h want=%h", data_out, 16'h0000);
        end
        @(negedge clk);
        rst_ = 1'b1;
        step();
        n_total++;
        if (data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_after got=%h want=%h", data_out, 16'h0000);
        end
    endtask

    task automatic test_count_up();
        logic [15:0] exp;
        ld_cnt = 1'b1; count_enb = 1'b1; updn_cnt = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = 16'(i);
            n_total++;
            if (data_out !== exp) begin
                n_bad++;
                $display("FAIL count_up[%0d] got=%h want=%h", i, data_out, exp);
            end
        end
        count_enb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_total++;
            if (data_out !== 16'd10) begin
                n_bad++;
                $display("FAIL hold[%0d] got=%h want=%h", i, data_out, 16'd10);
            end
        end
    endtask

    task automatic test_load();
        data_in = 16'h007F; ld_cnt = 1'b0; count_enb = 1'b0;
        step();
        n_total++;
        if (data_out !== 16'd127) begin
            n_bad++;
            $display("FAIL load_idle got=%h want=%h", data_out, 16'd127);
        end
        data_in = 16'h007F; count_enb = 1'b1; updn_cnt = 1'b0;
        step();
        n_total++;
        if (data_out !== 16'd127) begin
            n_bad++;
            $display("FAIL load_over_count got=%h want=%h", data_out, 16'd127);
        end
        ld_cnt = 1'b1;
    endtask

    task automatic test_count_down();
        logic [15:0] exp;
        updn_cnt = 1'b0; count_enb = 1'b1; ld_cnt = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            exp = 16'(127 - i);
            n_total++;
            if (data_out !== exp) begin
                n_bad++;
                $display("FAIL count_down[%0d] got=%h want=%h", i, data_out, exp);
            end
        end
    endtask

    task automatic test_wrap();
        rst_ = 1'b0;
        ld_cnt = 1'b1; updn_cnt = 1'b0; count_enb = 1'b1;
        #1;
        n_total++;
        if (data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_reset got=%h want=%h", data_out, 16'h0000);
        end
        @(negedge clk);
        rst_ = 1'b1;
        step();
        n_total++;
        if (data_out !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_down1 got=%h want=%h", data_out, 16'hFFFF);
        end
        step();
        n_total++;
        if (data_out !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL wrap_down2 got=%h want=%h", data_out, 16'hFFFE);
        end
        ld_cnt = 1'b0; data_in = 16'hFFFF;
        step();
        n_total++;
        if (data_out !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_load got=%h want=%h", data_out, 16'hFFFF);
        end
        ld_cnt = 1'b1; updn_cnt = 1'b1;
        step();
        n_total++;
        if (data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_up got=%h want=%h", data_out, 16'h0000);
        end
    endtask

    task automatic test_async_reset();
        ld_cnt = 1'b1; updn_cnt = 1'b1; count_enb = 1'b1; data_in = 16'h5A5A;
        step();
        step();
        step();
        n_total++;
        if (data_out !== 16'd3) begin
            n_bad++;
            $display("FAIL async_pre got=%h want=%h", data_out, 16'd3);
        end
        #2;
        rst_ = 1'b0;
        #1;
        n_total++;
        if (data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_immediate got=%h want=%h", data_out, 16'h0000);
        end
        step();
        n_total++;
        if (data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_held got=%h want=%h", data_out, 16'h0000);
        end
        @(negedge clk);
        rst_ = 1'b1;
        step();
        n_total++;
        if (data_out !== 16'd1) begin
            n_bad++;
            $display("FAIL async_resume1 got=%h want=%h", data_out, 16'd1);
        end
        step();
        n_total++;
        if (data_out !== 16'd2) begin
            n_bad++;
            $display("FAIL async_resume2 got=%h want=%h", data_out, 16'd2);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_count_up();
        test_load();
        test_count_down();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
